// File: rtl/phy_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : phy_cfg_if
// Description : MDIO serializer link between the PHY configuration sequencer
//               (master) and the serializer / PHY (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface phy_cfg_if;
  logic        mdc;        // management clock, shared by serializer and PHY
  logic        start;      // low clears the serializer, high runs it
  logic [23:0] mdio_data;  // {3'b000, reg_addr[4:0], reg_data[15:0]}
  logic        tr_end;     // transaction end, mdc domain

  modport master (output mdc, output start, output mdio_data, input tr_end);
  modport slave  (input mdc, input start, input mdio_data, output tr_end);
endinterface
`default_nettype wire

// File: rtl/phy_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : phy_cfg_seq
// Description : Power-on PHY register configuration sequencer. Generates mdc,
//               walks a 4-entry (addr, data) table through an external MDIO
//               serializer, with a RUN timeout and a restart request.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_cfg_seq #(
  parameter int CLK_DIV    = 1250,
  parameter int POR_WAIT   = 1000000,
  parameter int TO_PERIODS = 40
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic cfg_restart,
  output logic      busy,
  output logic      done,
  output logic      err,
  phy_cfg_if.master bus
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_POR_W = $clog2(POR_WAIT + 1);
  localparam int c_PER_W = $clog2(TO_PERIODS + 3);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_POR_W-1:0] c_POR_LAST  = c_POR_W'(POR_WAIT - 1);
  localparam logic [c_PER_W-1:0] c_TO_LAST   = c_PER_W'(TO_PERIODS - 1);
  // Quiet mdc periods required in LOAD before the serializer is enabled
  localparam logic [c_PER_W-1:0] c_LOAD_PERS = c_PER_W'(2);

  typedef enum logic [2:0] {
    ST_POR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  logic [c_DIV_W-1:0] r_div;
  logic               r_mdc;
  logic               w_mdc_fall;
  logic               r_tr_s1, r_tr_s2, r_tr_d;
  logic               w_tr_rise;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_idx, w_idx_nxt;
  logic               r_start, w_start_nxt;
  logic [23:0]        r_data, w_data_nxt;
  logic [c_PER_W-1:0] r_per, w_per_nxt;
  logic [c_POR_W-1:0] r_por, w_por_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  // Configuration table: register address and value per entry
  function automatic logic [23:0] f_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    f_entry = {3'b000, 5'h00, 16'h1140};
      2'd1:    f_entry = {3'b000, 5'h04, 16'h01E1};
      2'd2:    f_entry = {3'b000, 5'h09, 16'h0200};
      default: f_entry = {3'b000, 5'h00, 16'h1340};
    endcase
  endfunction

  // mdc divider: toggle at terminal count, flag the high-to-low toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (r_div == c_DIV_LAST) begin
      r_div <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_mdc_fall = (r_div == c_DIV_LAST) && r_mdc;

  // Two-flop synchronizer for tr_end plus a delay flop for rise detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tr_s1 <= 1'b0;
      r_tr_s2 <= 1'b0;
      r_tr_d  <= 1'b0;
    end else begin
      r_tr_s1 <= bus.tr_end;
      r_tr_s2 <= r_tr_s1;
      r_tr_d  <= r_tr_s2;
    end
  end

  assign w_tr_rise = r_tr_s2 && !r_tr_d;

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_POR;
      r_idx   <= 2'd0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_per   <= '0;
      r_por   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_start <= w_start_nxt;
      r_data  <= w_data_nxt;
      r_per   <= w_per_nxt;
      r_por   <= w_por_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; start/mdio_data only move on an mdc falling edge
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start_nxt = r_start;
    w_data_nxt  = r_data;
    w_per_nxt   = r_per;
    w_por_nxt   = r_por;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    case (r_state)
      ST_POR: begin
        if (r_por == c_POR_LAST) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = 2'd0;
          w_per_nxt   = '0;
        end else begin
          w_por_nxt = r_por + 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_mdc_fall) begin
          w_data_nxt = f_entry(r_idx);
        end
        // A stale tr_end from the previous word restarts the quiet count
        if (r_tr_s2) begin
          w_per_nxt = '0;
        end else if (w_mdc_fall) begin
          if (r_per == c_LOAD_PERS) begin
            w_start_nxt = 1'b1;
            w_per_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_per_nxt = r_per + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_tr_rise) begin
          w_state_nxt = ST_GAP;
        end else if (w_mdc_fall) begin
          if (r_per == c_TO_LAST) begin
            w_start_nxt = 1'b0;
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_per_nxt = r_per + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (w_mdc_fall) begin
          w_start_nxt = 1'b0;
          if (r_idx == 2'd3) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_data_nxt  = f_entry(r_idx + 2'd1);
            w_per_nxt   = '0;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        if (cfg_restart) begin
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_idx_nxt   = 2'd0;
          w_per_nxt   = '0;
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_POR;
      end
    endcase
  end

  assign bus.mdc       = r_mdc;
  assign bus.start     = r_start;
  assign bus.mdio_data = r_data;
  assign busy          = ~r_done;
  assign done          = r_done;
  assign err           = r_err;

endmodule
`default_nettype wire
